// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI register map, fetch FSM states and header length
package spi_pkg;
   typedef enum logic [1:0] {IDLE, WR, WT, RD} state_t;
   localparam logic [2:0] DATA_END = 3'd0;
   localparam logic [2:0] DATA     = 3'd1;
   localparam logic [2:0] STATUS   = 3'd2;
   localparam logic [2:0] INTR     = 3'd3;
   localparam logic [2:0] MODE     = 3'd4;
   localparam logic [2:0] CLKDIV   = 3'd5;
   localparam logic [4:0] HDR_LEN  = 5'd4;
endpackage

// File: rtl/spi_fetch.sv
// spi_fetch: flash read engine sharing the SPI register port with the CPU
module spi_fetch
   import spi_pkg::*;
#(
   parameter logic [1:0] SEL = 2'd0,
   parameter logic [7:0] CMD = 8'h03
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [23:0] req_addr,
   input  logic [3:0]  req_len,
   output logic        busy,
   output logic        rd_valid,
   output logic [7:0]  rd_data,
   output logic        done,
   input  logic [2:0]  cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic [1:0]  cpu_sel,
   input  logic        cpu_read,
   input  logic        cpu_write,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_stall,
   output logic        cpu_interrupt,
   output logic [2:0]  spi_addr,
   output logic [7:0]  spi_wdata,
   output logic [1:0]  spi_sel,
   output logic        spi_read,
   output logic        spi_write,
   input  logic [7:0]  spi_rdata,
   input  logic        spi_interrupt
);
   state_t      state, state_nxt;
   logic [4:0]  idx, idx_nxt;
   logic [23:0] addr;
   logic [3:0]  len;
   logic        cpu_own, idle, hdr, last, grant;
   logic [7:0]  hdr_byte;

   assign idle  = state == IDLE;
   assign busy  = !idle;
   assign hdr   = idx < HDR_LEN;
   assign last  = idx == HDR_LEN + {1'b0, len};
   assign grant = idle && req && !cpu_own && !cpu_read && !cpu_write;
   assign hdr_byte = !hdr ? 8'h00 : idx[1:0] == 2'd0 ? CMD : idx[1:0] == 2'd1 ? addr[23:16] :
                     idx[1:0] == 2'd2 ? addr[15:8] : addr[7:0];

   // CPU owns the port in IDLE; strobes are held low while reset is asserted
   assign spi_write     = !reset && (idle ? cpu_write : state == WR);
   assign spi_read      = !reset && (idle ? cpu_read : state == RD);
   assign spi_sel       = idle ? cpu_sel : SEL;
   assign spi_wdata     = idle ? cpu_data_in : hdr_byte;
   assign spi_addr      = idle ? cpu_addr : state == WR ? (idx == 5'd0 ? DATA_END : DATA) :
                          (state == RD && last) ? DATA_END : DATA;
   assign cpu_data_out  = idle ? spi_rdata : 8'h00;
   assign cpu_interrupt = idle && spi_interrupt;
   assign cpu_stall     = !reset && !idle && (cpu_read || cpu_write);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: if (grant) begin
            state_nxt = WR;
            idx_nxt   = 5'd0;
         end
         WR: state_nxt = WT;
         WT: if (spi_interrupt) begin
            state_nxt = hdr ? WR : RD;
            idx_nxt   = hdr ? idx + 5'd1 : idx;
         end
         RD: begin
            state_nxt = last ? IDLE : WR;
            idx_nxt   = last ? 5'd0 : idx + 5'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= 5'd0;
         addr     <= 24'd0;
         len      <= 4'd0;
         cpu_own  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= 8'h00;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         rd_valid <= state == RD;
         done     <= state == RD && last;
         if (state == RD) rd_data <= spi_rdata;
         if (grant) begin
            addr <= req_addr;
            len  <= req_len;
         end
         if (idle && cpu_write && cpu_addr == DATA_END) cpu_own <= 1'b1;
         else if (idle && cpu_read && cpu_addr == DATA_END) cpu_own <= 1'b0;
      end
   end
endmodule

// File: tb/tb_spi_fetch.sv
// tb_spi_fetch: randomized fetches against a looping flash / SPI register model
module tb_spi_fetch;
   localparam logic [1:0] SEL = 2'd0;
   localparam logic [7:0] CMD = 8'h03;

   logic        clk = 1'b0, reset = 1'b1, req = 1'b0;
   logic [23:0] req_addr = 24'd0;
   logic [3:0]  req_len = 4'd0;
   logic        busy, rd_valid, done;
   logic [7:0]  rd_data;
   logic [2:0]  cpu_addr = 3'd0;
   logic [7:0]  cpu_data_in = 8'h00;
   logic [1:0]  cpu_sel = 2'd2;
   logic        cpu_read = 1'b0, cpu_write = 1'b0;
   logic [7:0]  cpu_data_out;
   logic        cpu_stall, cpu_interrupt;
   logic [2:0]  spi_addr;
   logic [7:0]  spi_wdata;
   logic [1:0]  spi_sel;
   logic        spi_read, spi_write;
   logic [7:0]  spi_rdata;
   logic        spi_interrupt;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   spi_fetch #(.SEL(SEL), .CMD(CMD)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
      .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
      .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_sel(cpu_sel),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_data_out(cpu_data_out),
      .cpu_stall(cpu_stall), .cpu_interrupt(cpu_interrupt),
      .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_sel(spi_sel),
      .spi_read(spi_read), .spi_write(spi_write),
      .spi_rdata(spi_rdata), .spi_interrupt(spi_interrupt)
   );

   function automatic logic [7:0] flash(input logic [23:0] a);
      return (a[7:0] * 8'd7 + a[15:8] * 8'd3 + a[23:16]) ^ 8'hA5;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // SPI peripheral: a write starts/continues a CS-low window, a DATA_END read closes it
   logic       cs_low = 1'b0, int_m = 1'b0;
   logic [7:0] rx = 8'h00, pend = 8'h00;
   int         cnt = 0, windows = 0;
   logic [7:0] mosi_q[$], last_mosi[$];
   assign spi_interrupt = int_m;
   assign spi_rdata = rx;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_low <= 1'b0;
         int_m <= 1'b0;
         rx <= 8'h00;
         cnt <= 0;
         mosi_q.delete();
      end else begin
         if (spi_write && spi_sel == SEL) begin
            if (!cs_low) begin
               mosi_q.delete();
               windows++;
            end
            pend = mosi_q.size() >= 4 ?
                   flash({mosi_q[1], mosi_q[2], mosi_q[3]} + 24'(mosi_q.size() - 4)) : 8'hFF;
            mosi_q.push_back(spi_wdata);
            cs_low <= 1'b1;
            int_m <= 1'b0;
            cnt <= $urandom_range(1, 4);
         end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
               int_m <= 1'b1;
               rx <= pend;
            end
         end
         if (spi_read && spi_sel == SEL && spi_addr == 3'd0) begin
            cs_low <= 1'b0;
            last_mosi = mosi_q;
         end
      end
   end

   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      if (!reset) begin
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected: got %0h expected no byte", rd_data);
            end else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
         end
         if (done) chk("done_with_last_valid", 32'(rd_valid), 32'd1);
         if (busy)
            chk("nonidle_port", 32'({cpu_interrupt, cpu_stall, (spi_read | spi_write) && spi_sel != SEL}),
                32'({1'b0, cpu_read | cpu_write, 1'b0}));
         else
            chk("idle_mux", 32'({spi_write, spi_read, spi_addr, spi_sel, spi_wdata, cpu_data_out, cpu_interrupt, cpu_stall}),
                32'({cpu_write, cpu_read, cpu_addr, cpu_sel, cpu_data_in, spi_rdata, spi_interrupt, 1'b0}));
      end
   end

   task automatic finish(input logic [23:0] a, input logic [3:0] l, input bit poke, input bit abort);
      int w0, k;
      bit ok;
      logic [7:0] em[$];
      w0 = windows;
      k = 0;
      ok = 0;
      em = {CMD, a[23:16], a[15:8], a[7:0]};
      for (int i = 0; i <= int'(l); i++) begin
         exp_q.push_back(flash(a + 24'(i)));
         em.push_back(8'h00);
      end
      @(posedge clk); #1;
      req = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         cpu_write = poke && c >= 1 && c < 4;
         cpu_sel = 2'd2;
         cpu_addr = 3'd1;
         @(negedge clk);
         if (cpu_write) chk("stall_during_fetch", 32'(cpu_stall), 32'd1);
         if (rd_valid) k++;
         if (abort && k == 3) begin
            #2 reset = 1'b1;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_strobes", 32'({spi_write, spi_read, cpu_stall}), 32'd0);
            chk("abort_cs_high", 32'(cs_low), 32'd0);
            exp_q.delete();
            @(posedge clk); #1;
            reset = 1'b0;
            return;
         end
         if (done) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      cpu_write = 1'b0;
      chk("done_seen", 32'(ok), 32'd1);
      chk("byte_count", 32'(k), 32'(l) + 32'd1);
      chk("exp_drained", 32'(exp_q.size()), 32'd0);
      chk("mosi_len", 32'(last_mosi.size()), 32'(em.size()));
      for (int i = 0; i < em.size() && i < last_mosi.size(); i++)
         chk("mosi_byte", 32'(last_mosi[i]), 32'(em[i]));
      chk("cs_windows", 32'(windows - w0), 32'd1);
      chk("cs_high_after", 32'(cs_low), 32'd0);
      exp_q.delete();
   endtask

   task automatic fetch(input logic [23:0] a, input logic [3:0] l, input bit poke, input bit abort);
      bit ok = 0;
      @(posedge clk); #1;
      req_addr = a;
      req_len = l;
      req = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("grant", 32'(ok), 32'd1);
      if (ok) finish(a, l, poke, abort);
      else req = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      cpu_write = 1'b1;
      cpu_read = 1'b1;
      cpu_sel = SEL;
      @(negedge clk);
      chk("reset_state", 32'({busy, rd_valid, done, rd_data, spi_write, spi_read, cpu_stall}), 32'd0);
      chk("flash_model_pin", 32'(flash(24'h012345)), 32'hE8);
      cpu_write = 1'b0;
      cpu_read = 1'b0;
      cpu_sel = 2'd2;
      @(posedge clk); #1;
      reset = 1'b0;

      fetch(24'h012345, 4'd0, 0, 0);
      chk("lit_hdr", 32'({last_mosi[0], last_mosi[1], last_mosi[2], last_mosi[3]}), 32'h03012345);
      chk("lit_data_mosi", 32'(last_mosi[4]), 32'h00);
      chk("lit_rd", 32'(rd_data), 32'hE8);

      fetch(24'h4000F0, 4'd15, 0, 0);
      fetch(24'hFFFFF8, 4'd15, 0, 0);

      // CPU takes ownership with a DATA_END write; fetch waits for the closing read
      @(posedge clk); #1;
      cpu_write = 1'b1; cpu_addr = 3'd0; cpu_sel = 2'd2;
      req = 1'b1; req_addr = 24'h00FFFE; req_len = 4'd3;
      @(negedge clk);
      chk("own_no_grant", 32'(busy), 32'd0);
      @(posedge clk); #1;
      cpu_write = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("own_blocks", 32'(busy), 32'd0);
         @(posedge clk); #1;
      end
      cpu_read = 1'b1; cpu_addr = 3'd0;
      @(negedge clk);
      chk("own_release_cycle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      cpu_read = 1'b0;
      @(negedge clk);
      chk("own_grant_cycle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("own_granted", 32'(busy), 32'd1);
      if (busy) finish(24'h00FFFE, 4'd3, 0, 0);
      else req = 1'b0;

      // same-cycle CPU write and req: CPU wins, then fetch with CPU accesses stalled
      @(posedge clk); #1;
      cpu_write = 1'b1; cpu_addr = 3'd2; cpu_sel = 2'd2; cpu_data_in = 8'h5C;
      req = 1'b1; req_addr = 24'hABCDEF; req_len = 4'd2;
      @(negedge clk);
      chk("tie_no_grant", 32'(busy), 32'd0);
      chk("tie_forward", 32'({spi_write, spi_sel, spi_addr, spi_wdata}), 32'({1'b1, 2'd2, 3'd2, 8'h5C}));
      @(posedge clk); #1;
      cpu_write = 1'b0;
      @(negedge clk);
      chk("tie_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tie_grant", 32'(busy), 32'd1);
      if (busy) finish(24'hABCDEF, 4'd2, 1, 0);
      else req = 1'b0;

      fetch(24'h123456, 4'd7, 0, 1);
      fetch(24'h123456, 4'd7, 0, 0);

      for (int i = 0; i < 8; i++)
         fetch(24'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_fetch.md
SPI_FETCH -- requirements
Module: spi_fetch

Interface
REQ-001 Parameter SEL, default 2'd0, SPI chip-select/channel used for the flash device.
REQ-002 Parameter CMD, default 8'h03, flash read opcode sent as first byte.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  1  fetch request; sampled in IDLE only.
REQ-006 req_addr  in  24  flash byte address, captured on grant.
REQ-007 req_len  in  4  bytes to read minus one (0 = 1 byte, 15 = 16 bytes), captured on grant.
REQ-008 busy  out  1  fetch in progress (state != IDLE).
REQ-009 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-010 rd_data  out  8  received flash byte.
REQ-011 done  out  1  one-cycle pulse after last byte delivered.
REQ-012 cpu_addr/cpu_data_in/cpu_sel/cpu_read/cpu_write  in  3/8/2/1/1  CPU register port toward SPI.
REQ-013 cpu_data_out  out  8; cpu_stall  out  1; cpu_interrupt  out  1.
REQ-014 spi_addr/spi_wdata/spi_sel/spi_read/spi_write  out  3/8/2/1/1  drive SPI register port.
REQ-015 spi_rdata  in  8 (combinational SPI read data); spi_interrupt  in  1.

Function
REQ-016 States: IDLE, WR, WT, RD; byte index idx (5 bits), header bytes idx 0..3, data bytes idx 4..4+req_len.
REQ-017 IDLE: SPI port muxed to CPU port; cpu_data_out = spi_rdata; cpu_interrupt = spi_interrupt; cpu_stall = 0.
REQ-018 cpu_own flag set on CPU write addr 0, cleared on CPU read addr 0; fetch not granted while cpu_own = 1.
REQ-019 Grant in IDLE when req = 1, cpu_own = 0, cpu_read = cpu_write = 0 (CPU wins same-cycle tie); next state WR, idx = 0.
REQ-020 Non-IDLE: CPU access not forwarded, cpu_stall = cpu_read|cpu_write, cpu_interrupt = 0.
REQ-021 WR: spi_write = 1 for exactly one cycle, spi_sel = SEL, spi_addr = 0 when idx = 0 else 1; spi_wdata = CMD, A[23:16], A[15:8], A[7:0], then 8'h00 for data bytes; next WT.
REQ-022 WT: wait for spi_interrupt = 1 (never true in first WT cycle because the write clears it); header byte -> idx+1, WR; data byte -> RD.
REQ-023 RD: spi_read = 1 for one cycle, spi_addr = 0 on last data byte (ends SPI transaction, CS released) else 1; rd_data <= spi_rdata, rd_valid pulses next cycle.
REQ-024 RD non-last -> idx+1, WR; last -> IDLE, done pulses same cycle as final rd_valid.
REQ-025 Byte count: exactly req_len+1 rd_valid pulses per grant, in address order.
REQ-026 req held high in IDLE after done starts a new fetch next grant cycle; no back-to-back CS-held bursting.

Reset
REQ-027 Reset asynchronously forces IDLE, idx = 0, cpu_own = 0, busy = rd_valid = done = 0, rd_data = 0.
REQ-028 All spi_* strobes and cpu_stall are 0 during reset; SPI block shares reset, so reset mid-fetch leaves both idle with CS high.

Structure
REQ-029 Shared package spi_pkg: state enum, SPI register constants (DATA_END = 0, DATA = 1, STATUS = 2, INTR = 3, MODE = 4, CLKDIV = 5), header length 4.
REQ-030 No sub-module; port mux, FSM and idx counter inline.

Verification (bench instantiates spi with looping flash model)
REQ-031 req_addr = 24'h012345, req_len = 0 -> MOSI bytes 03 01 23 45 00, one rd_valid with model byte, done, CS high after.
REQ-032 req_len = 15 -> 16 rd_valid pulses, data = model[addr..addr+15], single CS-low window.
REQ-033 CPU write addr 0 then req = 1 -> no grant until CPU read addr 0; grant the following IDLE cycle.
REQ-034 CPU write and req in same IDLE cycle -> CPU forwarded, fetch waits; CPU access during fetch -> cpu_stall = 1, no spi strobe.
REQ-035 Reset asserted during data byte 3 -> busy = 0 and CS = 3'b111 immediately; new fetch afterwards completes correctly.
